// File: rtl/add_sub_scheduler.sv
// Two-requester round-robin scheduler feeding a shared +/-1 accumulator.
// Define ADD_SUB_SAT_EN for saturating arithmetic; default build wraps modulo 2^WIDTH.
module add_sub_scheduler #(
  parameter int WIDTH = 4,
  parameter int STEPW = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [1:0]         req_op_i,
  input  logic [2*STEPW-1:0] req_steps_i,
  output logic [WIDTH-1:0]   out_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               done_id_o,
  output logic               sat_o
);

  // state | meaning
  // IDLE  | waiting for a request; grants one requester combinationally
  // RUN   | applying one +/-1 step per clock until remaining is exhausted
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             prio_q;
  logic             op_q;
  logic             id_q;
  logic [STEPW-1:0] remaining_q;
  logic [WIDTH-1:0] acc_q;

  logic             any_valid;
  logic             grant;
  logic             accept;
  logic             grant_op;
  logic [STEPW-1:0] grant_steps;
  logic [WIDTH-1:0] acc_raw;
  logic [WIDTH-1:0] acc_next;

  // Grant is withheld while reset is asserted so nothing is handed out before release.
  always_comb begin
    any_valid   = |req_valid_i;
    grant       = (&req_valid_i) ? prio_q : req_valid_i[1];
    accept      = reset_ni && (state_q == IDLE) && any_valid;
    req_ready_o = 2'b00;
    if (accept) begin
      req_ready_o[grant] = 1'b1;
    end
    grant_op    = req_op_i[grant];
    grant_steps = grant ? req_steps_i[STEPW +: STEPW] : req_steps_i[0 +: STEPW];
  end

  assign acc_raw = op_q ? (acc_q - WIDTH'(1)) : (acc_q + WIDTH'(1));

`ifdef ADD_SUB_SAT_EN
  logic clip;
  logic sat_q;

  assign clip     = op_q ? (acc_q == '0) : (acc_q == '1);
  assign acc_next = clip ? acc_q : acc_raw;
  assign sat_o    = sat_q;
`else
  assign acc_next = acc_raw;
  assign sat_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      op_q        <= 1'b0;
      id_q        <= 1'b0;
      remaining_q <= '0;
      acc_q       <= '0;
`ifdef ADD_SUB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
`ifdef ADD_SUB_SAT_EN
      sat_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q        <= grant_op;
            id_q        <= grant;
            prio_q      <= ~grant;
            remaining_q <= grant_steps;
            state_q     <= (grant_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc_q       <= acc_next;
          remaining_q <= remaining_q - STEPW'(1);
`ifdef ADD_SUB_SAT_EN
          sat_q       <= clip;
`endif
          if (remaining_q == STEPW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_o     = acc_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign done_id_o = id_q;

endmodule

// File: tb/tb_add_sub_scheduler.sv
// Scoreboard bench for add_sub_scheduler: directed commands push expected completions,
// a negedge monitor pops and compares on every done_o pulse.
module tb_add_sub_scheduler;
  localparam int WIDTH = 4;
  localparam int STEPW = 4;
`ifdef ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               reset_ni = 1'b0;
  logic [1:0]         req_valid_i = 2'b00;
  logic [1:0]         req_ready_o;
  logic [1:0]         req_op_i = 2'b00;
  logic [2*STEPW-1:0] req_steps_i = '0;
  logic [WIDTH-1:0]   out_o;
  logic               busy_o;
  logic               done_o;
  logic               done_id_o;
  logic               sat_o;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  logic grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   done_seen = 0;
  int   sat_cnt = 0;

  add_sub_scheduler #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_steps_i (req_steps_i),
    .out_o       (out_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .done_id_o   (done_id_o),
    .sat_o       (sat_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_exp(logic id, logic [WIDTH-1:0] val);
    exp_t e;
    e.id  = id;
    e.val = val;
    exp_q.push_back(e);
  endfunction

  // Monitor: grant log, sat pulse count, and scoreboard compare on done_o.
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_ni) begin
      if (|req_ready_o) check("ready_onehot", int'(req_ready_o != 2'b11), 1);
      if (|(req_ready_o & req_valid_i)) grant_log.push_back(req_ready_o[1]);
      if (sat_o) sat_cnt++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: id %0d out %0d with no command pending",
                   done_id_o, out_o);
        end else begin
          e = exp_q.pop_front();
          check("done_id", int'(done_id_o), int'(e.id));
          check("done_out", int'(out_o), int'(e.val));
        end
        done_seen++;
      end
    end
  end

  task automatic wait_ready(int r, output int acc_cyc);
    int n = 0;
    acc_cyc = -1;
    @(negedge clk_i);
    while (!req_ready_o[r]) begin
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: requester %0d never granted, expected a grant", r);
        return;
      end
      @(negedge clk_i);
    end
    acc_cyc = cycle;
  endtask

  task automatic send(int r, logic op, int steps, output int acc_cyc);
    @(posedge clk_i); #1;
    req_valid_i[r] = 1'b1;
    req_op_i[r] = op;
    req_steps_i[r*STEPW +: STEPW] = STEPW'(steps);
    wait_ready(r, acc_cyc);
    @(posedge clk_i); #1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic collect_grants(int k);
    int g = 0;
    int n = 0;
    while (g < k) begin
      @(negedge clk_i);
      if (|(req_ready_o & req_valid_i)) g++;
      n++;
      if (n > 80) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout: got %0d grants expected %0d", g, k);
        break;
      end
    end
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
  endtask

  task automatic wait_done(int target);
    int n = 0;
    while (done_seen < target) begin
      @(negedge clk_i); #1;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: done count %0d expected %0d", done_seen, target);
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, base, d, sb, start;

    // Reset state, with a request already pending
    req_valid_i = 2'b01;
    req_op_i = 2'b00;
    req_steps_i = {4'd0, 4'd3};
    repeat (2) @(negedge clk_i);
    check("rst_out", int'(out_o), 0);
    check("rst_ready", int'(req_ready_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_done_id", int'(done_id_o), 0);
    check("rst_sat", int'(sat_o), 0);

    // Single command: r0 add 3
    push_exp(1'b0, 4'd3);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    wait_ready(0, a0);
    @(posedge clk_i); #1;
    req_valid_i = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      check("t1_out", int'(out_o), i - 1);
      check("t1_busy", int'(busy_o), 1);
      check("t1_done", int'(done_o), int'(i == 4));
    end

    // Contention from reset: r0 add 2, r1 sub 5
    do_reset();
    d = done_seen;
    base = grant_log.size();
    sb = sat_cnt;
    push_exp(1'b0, 4'd2);
    push_exp(1'b1, SAT ? 4'd0 : 4'd13);
    fork
      send(0, 1'b0, 2, a0);
      send(1, 1'b1, 5, a1);
    join
    wait_done(d + 2);
    check("t2_grant0", int'(grant_log[base]), 0);
    check("t2_grant1", int'(grant_log[base+1]), 1);
    check("t2_accept_gap", a1 - a0, 4);
    check("t2_sat_pulses", sat_cnt - sb, SAT ? 3 : 0);
    check("t2_out", int'(out_o), SAT ? 0 : 13);

    // Fairness: both held valid, add 1 each
    start = SAT ? 0 : 13;
    d = done_seen;
    base = grant_log.size();
    for (int i = 0; i < 4; i++) push_exp(logic'(i % 2), WIDTH'(start + i + 1));
    @(posedge clk_i); #1;
    req_valid_i = 2'b11;
    req_op_i = 2'b00;
    req_steps_i = {4'd1, 4'd1};
    collect_grants(4);
    wait_done(d + 4);
    for (int i = 0; i < 4; i++) check("t3_grant", int'(grant_log[base+i]), i % 2);

    // Zero steps: r1 sub 0
    push_exp(1'b1, SAT ? 4'd4 : 4'd1);
    send(1, 1'b1, 0, a1);
    @(negedge clk_i);
    check("t4_done", int'(done_o), 1);
    check("t4_busy", int'(busy_o), 1);
    check("t4_out", int'(out_o), SAT ? 4 : 1);
    @(negedge clk_i);
    check("t4_busy_after", int'(busy_o), 0);
    check("t4_done_after", int'(done_o), 0);

    // Wrap / saturation boundary: reach 14, then add 3
    do_reset();
    d = done_seen;
    push_exp(1'b0, 4'd14);
    send(0, 1'b0, 14, a0);
    wait_done(d + 1);
    push_exp(1'b0, SAT ? 4'd15 : 4'd1);
    send(0, 1'b0, 3, a0);
    @(negedge clk_i);
    check("t5_out_a1", int'(out_o), 14);
    @(negedge clk_i);
    check("t5_out_a2", int'(out_o), 15);
    check("t5_sat_a2", int'(sat_o), 0);
    @(negedge clk_i);
    check("t5_out_a3", int'(out_o), SAT ? 15 : 0);
    check("t5_sat_a3", int'(sat_o), int'(SAT));
    @(negedge clk_i);
    check("t5_out_a4", int'(out_o), SAT ? 15 : 1);
    check("t5_sat_a4", int'(sat_o), int'(SAT));
    check("t5_done_a4", int'(done_o), 1);

    // Reset during RUN of add 10, then a contended restart
    @(negedge clk_i);
    d = done_seen;
    send(0, 1'b0, 10, a0);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    req_valid_i = 2'b11;
    req_op_i = 2'b00;
    req_steps_i = {4'd2, 4'd1};
    @(negedge clk_i);
    check("t6_rst_out", int'(out_o), 0);
    check("t6_rst_busy", int'(busy_o), 0);
    check("t6_rst_done", int'(done_o), 0);
    check("t6_rst_ready", int'(req_ready_o), 0);
    @(negedge clk_i);
    check("t6_no_done", done_seen - d, 0);
    base = grant_log.size();
    push_exp(1'b0, 4'd1);
    push_exp(1'b1, 4'd3);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    collect_grants(2);
    wait_done(d + 2);
    check("t6_grant0", int'(grant_log[base]), 0);
    check("t6_grant1", int'(grant_log[base+1]), 1);
    check("t6_out", int'(out_o), 3);

    repeat (3) @(negedge clk_i);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
